// File: rtl/mips_pkg.sv
// Shared definitions for the MIPS system: instruction-memory geometry defaults,
// the program-loader state encoding and a count-legality helper.
package mips_pkg;

    localparam int IMEM_DEPTH  = 256;
    localparam int IMEM_ADDR_W = 8;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        FLUSH,
        RUN,
        ERR
    } loader_state_e;

    // A load must contain at least one word and must fit in the memory.
    function automatic logic count_is_legal(input int unsigned count, input int unsigned depth);
        return (count != 0) && (count <= depth);
    endfunction

endpackage

// File: rtl/imem_loader_if.sv
// Bundle of the loader's control, streaming-source and instruction-memory signals.
// The loader takes the slave side; the surrounding system drives the master side.
interface imem_loader_if #(
    parameter int ADDR_W = mips_pkg::IMEM_ADDR_W
);
    import mips_pkg::*;

    logic              start;
    logic [ADDR_W:0]   word_count;
    logic              in_valid;
    logic [31:0]       in_data;
    logic              in_ready;
    logic              imem_we;
    logic [ADDR_W-1:0] imem_addr;
    logic [31:0]       imem_wdata;
    logic              core_reset;
    logic              done;
    logic              error;

    modport slave (
        input  start, word_count, in_valid, in_data,
        output in_ready, imem_we, imem_addr, imem_wdata, core_reset, done, error
    );

    modport master (
        output start, word_count, in_valid, in_data,
        input  in_ready, imem_we, imem_addr, imem_wdata, core_reset, done, error
    );

endinterface

// File: rtl/imem_loader.sv
// Streams a program into instruction memory while holding the core in reset,
// then releases the core. Writes are registered, one cycle after each handshake.
module imem_loader
    import mips_pkg::*;
#(
    parameter int DEPTH  = IMEM_DEPTH,
    parameter int ADDR_W = IMEM_ADDR_W
) (
    input  logic         clk,
    input  logic         reset,
    imem_loader_if.slave bus
);

    localparam logic [ADDR_W:0] CNT_ONE = 1;

    loader_state_e     state_q, state_d;
    logic [ADDR_W:0]   count_q, count_d;
    logic [ADDR_W:0]   cnt_q, cnt_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [31:0]       wdata_q, wdata_d;

    logic start_legal;
    logic handshake;
    logic last_word;

    assign start_legal = count_is_legal(32'(bus.word_count), DEPTH);
    assign handshake   = bus.in_valid && (state_q == LOAD);
    // cnt_q counts accepted words, so the final one arrives when it equals count-1.
    assign last_word   = (cnt_q == count_q - CNT_ONE);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            count_q <= '0;
            cnt_q   <= '0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            cnt_q   <= cnt_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
        end
    end

    always_comb begin
        state_d = state_q;
        count_d = count_q;
        cnt_d   = cnt_q;
        we_d    = 1'b0;
        addr_d  = addr_q;
        wdata_d = wdata_q;

        case (state_q)
            IDLE, RUN, ERR: begin
                if (bus.start) begin
                    if (start_legal) begin
                        state_d = LOAD;
                        count_d = bus.word_count;
                        cnt_d   = '0;
                    end else begin
                        state_d = ERR;
                    end
                end
            end
            LOAD: begin
                if (handshake) begin
                    we_d    = 1'b1;
                    addr_d  = cnt_q[ADDR_W-1:0];
                    wdata_d = bus.in_data;
                    cnt_d   = cnt_q + CNT_ONE;
                    if (last_word) begin
                        state_d = FLUSH;
                    end
                end
            end
            FLUSH: begin
                state_d = RUN;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Status outputs decode straight from the state so reset forces them at once.
    assign bus.in_ready   = (state_q == LOAD);
    assign bus.core_reset = (state_q != RUN);
    assign bus.done       = (state_q == RUN);
    assign bus.error      = (state_q == ERR);
    assign bus.imem_we    = we_q;
    assign bus.imem_addr  = addr_q;
    assign bus.imem_wdata = wdata_q;

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: a per-cycle vector table followed by
// hand-written full-depth and asynchronous-reset sequences.
module tb_imem_loader;
    import mips_pkg::*;

    logic clk = 1'b0;
    logic reset = 1'b1;

    imem_loader_if #(.ADDR_W(8)) bus ();

    imem_loader #(.DEPTH(256), .ADDR_W(8)) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit          rst;
        bit          start;
        logic [8:0]  wc;
        bit          valid;
        logic [31:0] data;
        bit          e_rdy;
        bit          e_we;
        logic [7:0]  e_addr;
        logic [31:0] e_wd;
        bit          e_cr;
        bit          e_done;
        bit          e_err;
    } vec_t;

    vec_t vecs[$];
    int   total  = 0;
    int   passed = 0;

    function automatic vec_t mk(bit r, bit s, logic [8:0] wc, bit v, logic [31:0] d,
                                bit rdy, bit we, logic [7:0] a, logic [31:0] wd,
                                bit cr, bit dn, bit er);
        vec_t t;
        t.rst = r;  t.start = s;  t.wc = wc;  t.valid = v;  t.data = d;
        t.e_rdy = rdy;  t.e_we = we;  t.e_addr = a;  t.e_wd = wd;
        t.e_cr = cr;  t.e_done = dn;  t.e_err = er;
        return t;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) $display("FAIL %s: got %h, expected %h", name, act, exp);
        else passed++;
    endtask

    task automatic drive(input bit s, input logic [8:0] wc, input bit v, input logic [31:0] d);
        bus.start      = s;
        bus.word_count = wc;
        bus.in_valid   = v;
        bus.in_data    = d;
    endtask

    initial begin
        int done_wait;
        drive(1'b0, 9'd0, 1'b0, 32'h0);

        //        rst st  wc    vl data          rdy we addr   wdata          cr dn er
        vecs.push_back(mk(1, 0, 9'd0,   0, 32'h0,        0, 0, 8'd0, 32'h0,        1, 0, 0));
        // three-word back-to-back load
        vecs.push_back(mk(0, 1, 9'd3,   0, 32'h0,        1, 0, 8'd0, 32'h0,        1, 0, 0));
        vecs.push_back(mk(0, 0, 9'd0,   1, 32'h00641020, 1, 1, 8'd0, 32'h00641020, 1, 0, 0));
        vecs.push_back(mk(0, 0, 9'd0,   1, 32'h00651822, 1, 1, 8'd1, 32'h00651822, 1, 0, 0));
        vecs.push_back(mk(0, 0, 9'd0,   1, 32'h8C040004, 0, 1, 8'd2, 32'h8C040004, 1, 0, 0));
        vecs.push_back(mk(0, 0, 9'd0,   1, 32'hDEADBEEF, 0, 0, 8'd2, 32'h8C040004, 0, 1, 0));
        // reload from RUN with gaps; start inside LOAD and FLUSH is ignored
        vecs.push_back(mk(0, 1, 9'd2,   0, 32'h0,        1, 0, 8'd2, 32'h8C040004, 1, 0, 0));
        vecs.push_back(mk(0, 0, 9'd0,   1, 32'h11111111, 1, 1, 8'd0, 32'h11111111, 1, 0, 0));
        vecs.push_back(mk(0, 1, 9'd5,   0, 32'h22222222, 1, 0, 8'd0, 32'h11111111, 1, 0, 0));
        vecs.push_back(mk(0, 0, 9'd0,   0, 32'h22222222, 1, 0, 8'd0, 32'h11111111, 1, 0, 0));
        vecs.push_back(mk(0, 0, 9'd0,   1, 32'h33333333, 0, 1, 8'd1, 32'h33333333, 1, 0, 0));
        vecs.push_back(mk(0, 1, 9'd1,   0, 32'h0,        0, 0, 8'd1, 32'h33333333, 0, 1, 0));
        // single-word reload from RUN
        vecs.push_back(mk(0, 1, 9'd1,   0, 32'h0,        1, 0, 8'd1, 32'h33333333, 1, 0, 0));
        vecs.push_back(mk(0, 0, 9'd0,   1, 32'hABCD0001, 0, 1, 8'd0, 32'hABCD0001, 1, 0, 0));
        vecs.push_back(mk(0, 0, 9'd0,   0, 32'h0,        0, 0, 8'd0, 32'hABCD0001, 0, 1, 0));
        // illegal counts, then a legal start clears error
        vecs.push_back(mk(0, 1, 9'd0,   0, 32'h0,        0, 0, 8'd0, 32'hABCD0001, 1, 0, 1));
        vecs.push_back(mk(0, 1, 9'd257, 1, 32'hBAD0BAD0, 0, 0, 8'd0, 32'hABCD0001, 1, 0, 1));
        vecs.push_back(mk(0, 1, 9'd1,   0, 32'h0,        1, 0, 8'd0, 32'hABCD0001, 1, 0, 0));
        vecs.push_back(mk(0, 0, 9'd0,   1, 32'h5555AAAA, 0, 1, 8'd0, 32'h5555AAAA, 1, 0, 0));
        vecs.push_back(mk(0, 0, 9'd0,   0, 32'h0,        0, 0, 8'd0, 32'h5555AAAA, 0, 1, 0));
        // reset after two handshakes of a five-word load
        vecs.push_back(mk(0, 1, 9'd5,   0, 32'h0,        1, 0, 8'd0, 32'h5555AAAA, 1, 0, 0));
        vecs.push_back(mk(0, 0, 9'd0,   1, 32'h01010101, 1, 1, 8'd0, 32'h01010101, 1, 0, 0));
        vecs.push_back(mk(0, 0, 9'd0,   1, 32'h02020202, 1, 1, 8'd1, 32'h02020202, 1, 0, 0));
        vecs.push_back(mk(1, 0, 9'd0,   1, 32'h03030303, 0, 0, 8'd0, 32'h0,        1, 0, 0));
        vecs.push_back(mk(0, 0, 9'd0,   1, 32'h04040404, 0, 0, 8'd0, 32'h0,        1, 0, 0));
        vecs.push_back(mk(0, 1, 9'd257, 0, 32'h0,        0, 0, 8'd0, 32'h0,        1, 0, 1));
        vecs.push_back(mk(0, 1, 9'd2,   0, 32'h0,        1, 0, 8'd0, 32'h0,        1, 0, 0));
        vecs.push_back(mk(0, 0, 9'd0,   1, 32'h06060606, 1, 1, 8'd0, 32'h06060606, 1, 0, 0));
        vecs.push_back(mk(0, 0, 9'd0,   1, 32'h07070707, 0, 1, 8'd1, 32'h07070707, 1, 0, 0));
        vecs.push_back(mk(0, 0, 9'd0,   0, 32'h0,        0, 0, 8'd1, 32'h07070707, 0, 1, 0));

        foreach (vecs[i]) begin
            @(negedge clk);
            reset = vecs[i].rst;
            drive(vecs[i].start, vecs[i].wc, vecs[i].valid, vecs[i].data);
            @(posedge clk);
            #1;
            check($sformatf("v%0d.in_ready", i),   32'(bus.in_ready),   32'(vecs[i].e_rdy));
            check($sformatf("v%0d.imem_we", i),    32'(bus.imem_we),    32'(vecs[i].e_we));
            check($sformatf("v%0d.imem_addr", i),  32'(bus.imem_addr),  32'(vecs[i].e_addr));
            check($sformatf("v%0d.imem_wdata", i), bus.imem_wdata,      vecs[i].e_wd);
            check($sformatf("v%0d.core_reset", i), 32'(bus.core_reset), 32'(vecs[i].e_cr));
            check($sformatf("v%0d.done", i),       32'(bus.done),       32'(vecs[i].e_done));
            check($sformatf("v%0d.error", i),      32'(bus.error),      32'(vecs[i].e_err));
            $display("vec %0d: rst=%0d start=%0d wc=%0d valid=%0d -> we=%0d addr=%0d wdata=%h done=%0d err=%0d",
                     i, vecs[i].rst, vecs[i].start, vecs[i].wc, vecs[i].valid,
                     bus.imem_we, bus.imem_addr, bus.imem_wdata, bus.done, bus.error);
        end

        // full-depth load from RUN: 256 consecutive writes, last one at 255
        @(negedge clk);
        drive(1'b1, 9'd256, 1'b0, 32'h0);
        @(posedge clk); #1;
        check("full.in_ready", 32'(bus.in_ready), 32'd1);
        for (int w = 0; w < 256; w++) begin
            @(negedge clk);
            drive(1'b0, 9'd0, 1'b1, 32'hC0000000 | 32'(w));
            @(posedge clk); #1;
            check($sformatf("full.we[%0d]", w),    32'(bus.imem_we),   32'd1);
            check($sformatf("full.addr[%0d]", w),  32'(bus.imem_addr), 32'(w));
            check($sformatf("full.wdata[%0d]", w), bus.imem_wdata,     32'hC0000000 | 32'(w));
        end
        $display("full-depth load: 256 words streamed");
        @(negedge clk);
        drive(1'b0, 9'd0, 1'b0, 32'h0);
        done_wait = 0;
        while (!bus.done && done_wait < 4) begin
            @(posedge clk); #1;
            done_wait++;
        end
        check("full.done_timeout", 32'(bus.done), 32'd1);
        check("full.done_latency", 32'(done_wait), 32'd1);
        check("full.last_addr", 32'(bus.imem_addr), 32'd255);
        check("full.core_reset", 32'(bus.core_reset), 32'd0);

        // asynchronous reset between clock edges during a load
        @(negedge clk);
        drive(1'b1, 9'd5, 1'b0, 32'h0);
        @(negedge clk);
        drive(1'b0, 9'd0, 1'b1, 32'h0A0A0A0A);
        @(posedge clk); #1;
        check("areset.pre_we", 32'(bus.imem_we), 32'd1);
        #2 reset = 1'b1;
        #1;
        check("areset.we", 32'(bus.imem_we), 32'd0);
        check("areset.in_ready", 32'(bus.in_ready), 32'd0);
        check("areset.core_reset", 32'(bus.core_reset), 32'd1);
        check("areset.wdata", bus.imem_wdata, 32'h0);
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk); #1;
        check("areset.post_we", 32'(bus.imem_we), 32'd0);
        check("areset.post_rdy", 32'(bus.in_ready), 32'd0);
        @(negedge clk);
        drive(1'b1, 9'd1, 1'b0, 32'h0);
        @(negedge clk);
        drive(1'b0, 9'd0, 1'b1, 32'h0B0B0B0B);
        @(posedge clk); #1;
        check("areset.restart_addr", 32'(bus.imem_addr), 32'd0);
        check("areset.restart_wdata", bus.imem_wdata, 32'h0B0B0B0B);
        @(negedge clk);
        drive(1'b0, 9'd0, 1'b0, 32'h0);
        @(posedge clk); #1;
        check("areset.run_done", 32'(bus.done), 32'd1);
        $display("async reset sequence complete");

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
